// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, owner tags
// and the arbitration pick function.
package riscv_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  // I wins only when D is absent or the starvation guard forces it through.
  function automatic logic arb_pick_i(input logic req_i, input logic req_d,
                                      input logic force_i);
    return req_i & (force_i | ~req_d);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive D wins over a waiting I request; o_hit flags
// that I must be granted next. Only instantiated with ARB_STARVE_GUARD_EN.
module arb_starve_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  localparam int unsigned   CW    = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] r_cnt;

  // Clear wins over increment so an I grant always restarts the count.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_C)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_hit = (r_cnt == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch (I) and data (D) ports onto one single-ported
// memory, one transaction at a time. Optional macro: ARB_STARVE_GUARD_EN.
//
// state    | meaning
// ST_IDLE  | arbitrate, latch winner's command
// ST_ISSUE | mem_req high, hold command until mem_gnt
// ST_WAIT  | wait for mem_rvalid, capture load/fetch data
// ST_RESP  | one-cycle done pulse to owner, requests ignored
module mem_port_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int          AW         = 32,
  parameter int          DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_i,
  output logic          stall_d
);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  arb_owner_e    r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_i_flush;

  logic          w_i_forced;
  logic          w_pick_i;
  logic          w_pick_d;
  logic          w_i_live;

`ifdef ARB_STARVE_GUARD_EN
  logic w_starve_inc;
  logic w_starve_clr;
  logic w_starve_hit;

  assign w_starve_inc = (r_state == ST_IDLE) & w_pick_d & i_req;
  assign w_starve_clr = (r_state == ST_IDLE) & w_pick_i;

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_starve_inc),
    .i_clr (w_starve_clr),
    .o_hit (w_starve_hit)
  );

  assign w_i_forced = w_starve_hit;
`else
  // Guard absent: fixed D-over-I priority, I is never forced through.
  localparam bit GUARD_ON = 1'b0 && (STARVE_MAX > 0);
  assign w_i_forced = GUARD_ON;
`endif

  assign w_pick_i = arb_pick_i(i_req, d_req, w_i_forced);
  assign w_pick_d = d_req & ~w_pick_i;

  // A fetch is still wanted only while i_req stays up for the whole transaction.
  assign w_i_live = i_req & ~r_i_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (d_req || i_req) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (mem_gnt)        w_state_nxt = ST_WAIT;
      ST_WAIT:  if (mem_rvalid)     w_state_nxt = ST_RESP;
      ST_RESP:                      w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    i_done  = 1'b0;
    d_done  = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        mem_req = 1'b1;
        mem_we  = r_we;
      end
      ST_RESP: begin
        i_done = (r_owner == OWN_I) & w_i_live;
        d_done = (r_owner == OWN_D);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= OWN_I;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_flush <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_i_flush <= 1'b0;
        if (w_pick_d) begin
          r_owner <= OWN_D;
          r_we    <= d_we;
          r_addr  <= d_addr;
          r_wdata <= d_wdata;
        end else if (w_pick_i) begin
          r_owner <= OWN_I;
          r_we    <= 1'b0;
          r_addr  <= i_addr;
          r_wdata <= '0;
        end
      end else if ((r_owner == OWN_I) && !i_req) begin
        r_i_flush <= 1'b1;
      end

      // Stores complete without touching d_rdata; flushed fetches are dropped.
      if ((r_state == ST_WAIT) && mem_rvalid && !r_we) begin
        if (r_owner == OWN_D) begin
          r_d_rdata <= mem_rdata;
        end else if (w_i_live) begin
          r_i_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign stall_i   = i_req & ~i_done;
  assign stall_d   = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every
// cycle, plus literal cycle expectations for each scenario.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b1;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall_i;
  logic          stall_d;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_i(stall_i), .stall_d(stall_d)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [logic [31:0]];
  int          rv_delay = 0;
  int          rv_cnt   = -1;
  logic [31:0] pend_addr = '0;
  logic        n_req = 1'b0, n_we = 1'b0;
  logic [31:0] n_addr = '0, n_wdata = '0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'hA5A5_A5A5;
  endfunction

  always @(negedge clk) begin
    n_req = mem_req; n_we = mem_we; n_addr = mem_addr; n_wdata = mem_wdata;
  end

  // Memory is not reset, so a response in flight survives a DUT reset.
  always @(posedge clk) begin : memory
    logic hs;
    hs = n_req & mem_gnt;
    #1;
    mem_rvalid = 1'b0;
    if (hs) begin
      pend_addr = n_addr;
      if (n_we) mem_arr[n_addr] = n_wdata;
      rv_cnt = rv_delay;
    end else if (rv_cnt > 0) begin
      rv_cnt--;
    end
    if (rv_cnt == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_read(pend_addr);
      rv_cnt     = -1;
    end
  end

  // ---------------- transaction-level model ----------------
  bit          model_ok = 0;
  bit          m_live = 0, m_d = 0, m_we = 0, m_granted = 0, m_answered = 0, m_abandon = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_i_rdata = '0, m_d_rdata = '0;
  int          m_starve = 0;
  bit          grants[$];

  always @(posedge clk) begin : model
    bit take_i;
    bit force_i;
    if (rst) begin
      m_live = 0; m_granted = 0; m_answered = 0; m_abandon = 0;
      m_i_rdata = '0; m_d_rdata = '0; m_starve = 0; model_ok = 1;
    end else if (!m_live) begin
`ifdef ARB_STARVE_GUARD_EN
      force_i = (m_starve == SMAX);
`else
      force_i = 1'b0;
`endif
      take_i = i_req && (!d_req || force_i);
      if (d_req || i_req) begin
        m_live = 1; m_granted = 0; m_answered = 0; m_abandon = 0;
        m_d     = !take_i;
        m_we    = take_i ? 1'b0 : d_we;
        m_addr  = take_i ? i_addr : d_addr;
        m_wdata = d_wdata;
        grants.push_back(m_d);
        if (take_i) m_starve = 0;
        else if (i_req && m_starve < SMAX) m_starve++;
      end
    end else if (m_answered) begin
      m_live = 0;
    end else begin
      if (!m_d && !i_req) m_abandon = 1;
      if (!m_granted) begin
        m_granted = mem_gnt;
      end else if (mem_rvalid) begin
        m_answered = 1;
        if (!m_we) begin
          if (m_d) m_d_rdata = mem_rdata;
          else if (!m_abandon) m_i_rdata = mem_rdata;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit e_mreq, e_idone, e_ddone;
    if (model_ok) begin
      e_mreq  = m_live && !m_granted;
      e_ddone = m_live && m_answered && m_d;
      e_idone = m_live && m_answered && !m_d && !m_abandon && i_req;
      check("mem_req", mem_req, e_mreq);
      check("i_done", i_done, e_idone);
      check("d_done", d_done, e_ddone);
      check("i_rdata", i_rdata, m_i_rdata);
      check("d_rdata", d_rdata, m_d_rdata);
      check("stall_i", stall_i, i_req & ~e_idone);
      check("stall_d", stall_d, d_req & ~e_ddone);
      if (e_mreq) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_we", mem_we, m_we);
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic        rec_mreq[32], rec_idone[32], rec_ddone[32], rec_stalli[32], rec_rv[32];
  logic [31:0] rec_maddr[32], rec_mwdata[32];
  int          gnt_from = 0, i_drop_at = -1, rst_at = -1;
  bit          hold = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Cycle 0 inputs are driven by the caller just before; ends at start of cycle n.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        tick();
        if (!hold && rec_idone[c-1]) i_req = 1'b0;
        if (!hold && rec_ddone[c-1]) d_req = 1'b0;
      end
      mem_gnt = (c >= gnt_from);
      rst     = (c == rst_at);
      if (c == i_drop_at) i_req = 1'b0;
      @(negedge clk);
      rec_mreq[c] = mem_req;   rec_idone[c] = i_done; rec_ddone[c] = d_done;
      rec_stalli[c] = stall_i; rec_rv[c] = mem_rvalid;
      rec_maddr[c] = mem_addr; rec_mwdata[c] = mem_wdata;
    end
    tick();
    rst = 1'b0;
    if (!hold && rec_idone[n-1]) i_req = 1'b0;
    if (!hold && rec_ddone[n-1]) d_req = 1'b0;
  endtask

  bit exp_order[6];
  int order[$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any;
    logic [31:0] keep;
`ifdef ARB_STARVE_GUARD_EN
    exp_order = '{1, 1, 1, 1, 0, 1};
`else
    exp_order = '{1, 1, 1, 1, 1, 1};
`endif
    mem_arr[32'h10]  = 32'h0050_0093;
    mem_arr[32'h100] = 32'hDEAD_BEEF;
    mem_arr[32'h20]  = 32'h1234_5678;

    // reset state
    tick();
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_i_done", i_done, 0);
    check("rst_d_done", d_done, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_i_rdata", i_rdata, 0);
    tick();
    rst = 1'b0;
    tick();

    // single fetch
    i_req = 1'b1; i_addr = 32'h10;
    run(5);
    check("f_stall0", rec_stalli[0], 1);
    check("f_stall2", rec_stalli[2], 1);
    check("f_stall3", rec_stalli[3], 0);
    check("f_mreq1", rec_mreq[1], 1);
    check("f_done2", rec_idone[2], 0);
    check("f_done3", rec_idone[3], 1);
    check("f_rdata", i_rdata, 32'h0050_0093);

    // contention: D before I
    i_req = 1'b1; i_addr = 32'h14;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    run(9);
    check("c_ddone3", rec_ddone[3], 1);
    check("c_idone3", rec_idone[3], 0);
    check("c_mreq4", rec_mreq[4], 0);
    check("c_mreq5", rec_mreq[5], 1);
    check("c_idone7", rec_idone[7], 1);
    check("c_drdata", d_rdata, 32'hDEAD_BEEF);
    check("c_irdata", i_rdata, 32'hA5A5_A5B1);

    // store with two cycles of backpressure
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h2A; gnt_from = 3;
    run(7);
    gnt_from = 0; d_we = 1'b0;
    check("s_mreq1", rec_mreq[1], 1);
    check("s_mreq3", rec_mreq[3], 1);
    check("s_mreq4", rec_mreq[4], 0);
    check("s_wdata1", rec_mwdata[1], 32'h2A);
    check("s_wdata3", rec_mwdata[3], 32'h2A);
    check("s_addr3", rec_maddr[3], 32'h0);
    check("s_ddone4", rec_ddone[4], 0);
    check("s_ddone5", rec_ddone[5], 1);
    check("s_drdata", d_rdata, 32'hDEAD_BEEF);

    // flush during WAIT, then a normal D load
    i_req = 1'b1; i_addr = 32'h20; rv_delay = 1; i_drop_at = 2;
    run(6);
    i_drop_at = -1; rv_delay = 0;
    any = 1'b0;
    for (int c = 0; c < 6; c++) any |= rec_idone[c];
    check("fl_no_idone", any, 0);
    check("fl_rv3", rec_rv[3], 1);
    check("fl_irdata", i_rdata, 32'hA5A5_A5B1);
    d_req = 1'b1; d_addr = 32'h20;
    run(5);
    check("fl_ddone3", rec_ddone[3], 1);
    check("fl_drdata", d_rdata, 32'h1234_5678);

    // reset while waiting, stale response afterwards
    keep = 32'h0;
    i_req = 1'b1; i_addr = 32'h30; rv_delay = 1; rst_at = 2; i_drop_at = 2;
    run(6);
    rst_at = -1; i_drop_at = -1; rv_delay = 0;
    any = 1'b0;
    for (int c = 0; c < 6; c++) any |= rec_idone[c] | rec_ddone[c];
    check("r_no_done", any, 0);
    check("r_stale_rv3", rec_rv[3], 1);
    check("r_mreq3", rec_mreq[3], 0);
    check("r_i_rdata", i_rdata, keep);
    check("r_d_rdata", d_rdata, keep);
    check("r_mem_addr", mem_addr, keep);
    check("r_mem_wdata", mem_wdata, keep);

    // both requests held continuously
    grants.delete();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    i_req = 1'b1; i_addr = 32'h44;
    hold = 1;
    run(24);
    hold = 0;
    d_req = 1'b0; i_req = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (rec_ddone[c]) order.push_back(1);
      if (rec_idone[c]) order.push_back(0);
    end
    check("st_count", order.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < order.size()) check($sformatf("st_dut_grant%0d", k), order[k], exp_order[k]);
      if (k < grants.size()) check($sformatf("st_model_grant%0d", k), grants[k], exp_order[k]);
    end

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
